id_ex_imm_pipe: RTL and testbench
=================================

# id_ex_imm_pipe

Pipeline register between decode (ID) and execute (EX) for the pipelined MIPS CPU, with the immediate-extension unit built in. Each cycle it takes the decoded instruction word, PC and extension select from ID, and produces a registered 32-bit extended immediate. The extension covers sign, zero, upper-immediate and branch-offset forms. It also registers the register specifiers and shamt, handles stall and flush from the hazard unit, and counts stall cycles for performance debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction this cycle.
- `id_instr`  in  32  instruction word from the IF/ID register.
- `id_pc`  in  32  PC of `id_instr`.
- `id_ext_op`  in  2  extension select: 00 SIGN, 01 ZERO, 10 LUI, 11 BRANCH.
- `ex_stall`  in  1  hazard unit holds EX contents.
- `ex_flush`  in  1  hazard unit squashes the instruction entering EX.
- `id_ready`  out  1  ID may advance; equals `!ex_stall`.
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_imm`  out  32  registered extended immediate.
- `ex_rs`, `ex_rt`, `ex_rd`  out  5 each  registered instr[25:21], [20:16], [15:11].
- `ex_shamt`  out  5  registered instr[10:6].
- `ex_pc`  out  32  registered PC.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `ex_stall`=1.

## Operation
- Extension is combinational on `id_instr[15:0]` (imm), before the register:
  - SIGN: {{16{imm[15]}}, imm}.
  - ZERO: {16'b0, imm}.
  - LUI: {imm, 16'b0}.
  - BRANCH: {{14{imm[15]}}, imm, 2'b00}.
- Register update, in priority order, evaluated each rising edge:
  1. `rst` (async): all outputs 0 and `stall_cnt` 0. Takes effect immediately, mid-stall or mid-flush included.
  2. `ex_flush`=1: `ex_valid`←0 and all data fields ←0, which is a NOP bubble (instr 0 = sll $0,$0,0). Flush wins over a simultaneous stall.
  3. `ex_stall`=1: all fields hold their values.
  4. Otherwise, `id_valid`=1: load the extended immediate, specifiers, shamt and PC, and set `ex_valid`←1.
  5. Otherwise, `id_valid`=0: load a bubble, same as flush.
- `stall_cnt` increments on each edge where `ex_stall`=1 and `rst`=0, including when a flush overrides. It saturates at all-ones and is never cleared except by reset.
- `id_ready` is purely combinational. It does not depend on `ex_flush`, because a flushed ID instruction is dropped and not held.

## Timing
- Latency: 1 cycle from ID inputs to EX outputs. There is no combinational path from ID inputs to EX outputs.
- `id_ready` has zero-cycle latency from `ex_stall`.
- A stall of N cycles holds EX contents for N edges. The ID values present on the first non-stalled edge are then loaded.
- Flush and stall asserted in the same cycle: a bubble is loaded and `stall_cnt` still increments.
- Reset values: `ex_valid`=0, `ex_imm`=0, `ex_rs`/`ex_rt`/`ex_rd`/`ex_shamt`=0, `ex_pc`=0, `stall_cnt`=0. `id_ready`=`!ex_stall` at all times.
- Deassertion of `rst` is synchronised outside this block. The first loading edge is the first edge with `rst` low.

## Structure
- The shared CPU package holds the EXT_SIGN/EXT_ZERO/EXT_LUI/EXT_BRANCH constants (2 bits) and the instruction field bit positions. The decoder uses the same constants.
- One combinational sub-module, `imm_ext`, takes imm16 and ext_op and outputs imm32. The register logic stays in `id_ex_imm_pipe`.

## Test plan
- LUI: `id_instr`=0x3C011234, ext_op=LUI, `id_valid`=1 → next edge `ex_imm`=0x12340000, `ex_rt`=1, `ex_valid`=1.
- Extension forms with imm=0x8000: SIGN → 0xFFFF8000; ZERO → 0x00008000. Branch imm=0xFFFF → 0xFFFFFFFC.
- Stall: load `id_pc`=0x00000040, then hold `ex_stall`=1 for 3 cycles while ID changes → EX fields unchanged, `id_ready`=0, `stall_cnt`=3. On the first free edge the new ID values appear.
- Flush: `ex_flush`=1 with `ex_stall`=1 and a valid ID → next edge `ex_valid`=0, `ex_imm`=0, `ex_pc`=0, `stall_cnt` +1.
- Bubble: `id_valid`=0, no stall or flush → `ex_valid`=0 and all data fields 0.
- Reset mid-stall: assert `rst` between edges during a stall → all outputs 0 immediately. Set `CNT_W`=2 and stall 5 cycles → `stall_cnt` saturates at 3.

Source files
------------

// File: rtl/id_ex_imm_pipe_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_imm_pipe_pkg
// Shared CPU definitions for the decode/execute boundary. The package holds:
//   - the immediate-extension select encoding, which the decoder also uses,
//   - the bit positions of the instruction fields,
//   - the record of data fields carried from ID into EX.
// ----------------------------------------------------------------------------
package id_ex_imm_pipe_pkg;

  // Immediate-extension select, driven by the decoder.
  typedef enum logic [1:0] {
    EXT_SIGN   = 2'b00,
    EXT_ZERO   = 2'b01,
    EXT_LUI    = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_op_e;

  // Bit positions of the MIPS instruction fields.
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned IMM_MSB   = 15;
  localparam int unsigned IMM_LSB   = 0;

  // Data fields held in the ID/EX register. All zeros is the NOP bubble.
  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [31:0] pc;
  } ex_data_t;

  localparam ex_data_t EX_BUBBLE = '0;

endpackage : id_ex_imm_pipe_pkg

// File: rtl/id_ex_imm_pipe_imm_ext.sv
// ----------------------------------------------------------------------------
// imm_ext
// Combinational immediate-extension unit. It widens the 16-bit instruction
// immediate to 32 bits in one of four forms:
//   SIGN   : sign-extended
//   ZERO   : zero-extended
//   LUI    : immediate in the upper half, lower half zero
//   BRANCH : sign-extended word offset shifted left by two
// Ports:
//   imm16  in  16  instruction bits [15:0]
//   ext_op in  2   extension select (ext_op_e encoding)
//   imm32  out 32  extended immediate
// ----------------------------------------------------------------------------
module imm_ext
  import id_ex_imm_pipe_pkg::*;
(
  input  logic [15:0] imm16,
  input  logic [1:0]  ext_op,
  output logic [31:0] imm32
);

  always_comb begin
    // NOTE: give the output a value before the case so no path leaves it
    // unassigned; an unassigned path in always_comb infers a latch.
    imm32 = {{16{imm16[15]}}, imm16};
    case (ext_op_e'(ext_op))
      EXT_SIGN:   imm32 = {{16{imm16[15]}}, imm16};
      EXT_ZERO:   imm32 = {16'b0, imm16};
      EXT_LUI:    imm32 = {imm16, 16'b0};
      EXT_BRANCH: imm32 = {{14{imm16[15]}}, imm16, 2'b00};
      default:    imm32 = {{16{imm16[15]}}, imm16};
    endcase
  end

endmodule : imm_ext

// File: rtl/id_ex_imm_pipe.sv
// ----------------------------------------------------------------------------
// id_ex_imm_pipe
// ID/EX pipeline register with the immediate-extension unit in front of it.
// It registers the extended immediate, the register specifiers, shamt and the
// PC, obeys stall/flush from the hazard unit, and keeps a saturating count of
// stalled cycles for performance debug.
// Update order on each rising edge: reset, flush (bubble), stall (hold),
// valid ID (load), idle ID (bubble).
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   id_valid   in   1      ID holds a real instruction
//   id_instr   in   32     instruction word from IF/ID
//   id_pc      in   32     PC of id_instr
//   id_ext_op  in   2      extension select
//   ex_stall   in   1      hold EX contents
//   ex_flush   in   1      squash the instruction entering EX
//   id_ready   out  1      ID may advance (!ex_stall)
//   ex_valid   out  1      EX holds a real instruction
//   ex_imm     out  32     registered extended immediate
//   ex_rs/rt/rd out 5      registered register specifiers
//   ex_shamt   out  5      registered shift amount
//   ex_pc      out  32     registered PC
//   stall_cnt  out  CNT_W  saturating count of stalled cycles
// ----------------------------------------------------------------------------
module id_ex_imm_pipe
  import id_ex_imm_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_pc,
  input  logic [1:0]       id_ext_op,
  input  logic             ex_stall,
  input  logic             ex_flush,
  output logic             id_ready,
  output logic             ex_valid,
  output logic [31:0]      ex_imm,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_shamt,
  output logic [31:0]      ex_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [31:0]      imm32;
  ex_data_t         id_data;

  logic             ex_valid_d, ex_valid_q;
  ex_data_t         ex_data_d,  ex_data_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  imm_ext u_imm_ext (
    .imm16  (id_instr[IMM_MSB:IMM_LSB]),
    .ext_op (id_ext_op),
    .imm32  (imm32)
  );

  // Fields presented by ID this cycle.
  always_comb begin
    id_data.imm   = imm32;
    id_data.rs    = id_instr[RS_MSB:RS_LSB];
    id_data.rt    = id_instr[RT_MSB:RT_LSB];
    id_data.rd    = id_instr[RD_MSB:RD_LSB];
    id_data.shamt = id_instr[SHAMT_MSB:SHAMT_LSB];
    id_data.pc    = id_pc;
  end

  // Next-state for the EX register. A flushed instruction is dropped, so
  // flush overrides stall; an idle ID slot also turns into a bubble.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_data_d  = ex_data_q;
    if (ex_flush) begin
      ex_valid_d = 1'b0;
      ex_data_d  = EX_BUBBLE;
    end else if (ex_stall) begin
      ex_valid_d = ex_valid_q;
      ex_data_d  = ex_data_q;
    end else if (id_valid) begin
      ex_valid_d = 1'b1;
      ex_data_d  = id_data;
    end else begin
      ex_valid_d = 1'b0;
      ex_data_d  = EX_BUBBLE;
    end
  end

  // Stall counter counts every stalled edge, including ones a flush overrides,
  // and sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ex_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_data_q   <= EX_BUBBLE;
      stall_cnt_q <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_data_q   <= ex_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_ready  = !ex_stall;
  assign ex_valid  = ex_valid_q;
  assign ex_imm    = ex_data_q.imm;
  assign ex_rs     = ex_data_q.rs;
  assign ex_rt     = ex_data_q.rt;
  assign ex_rd     = ex_data_q.rd;
  assign ex_shamt  = ex_data_q.shamt;
  assign ex_pc     = ex_data_q.pc;
  assign stall_cnt = stall_cnt_q;

endmodule : id_ex_imm_pipe

// File: tb/tb_id_ex_imm_pipe.sv
// ----------------------------------------------------------------------------
// tb_id_ex_imm_pipe
// Drives two instances of id_ex_imm_pipe from the same inputs: one with the
// default 16-bit stall counter and one with a 2-bit counter to exercise
// saturation. Expected values come from a behavioural model that tracks what
// EX should hold and the total number of stalled edges.
// ----------------------------------------------------------------------------
module tb_id_ex_imm_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [1:0]  id_ext_op;
  logic        ex_stall;
  logic        ex_flush;

  logic        id_ready,  s_id_ready;
  logic        ex_valid,  s_ex_valid;
  logic [31:0] ex_imm,    s_ex_imm;
  logic [4:0]  ex_rs,     s_ex_rs;
  logic [4:0]  ex_rt,     s_ex_rt;
  logic [4:0]  ex_rd,     s_ex_rd;
  logic [4:0]  ex_shamt,  s_ex_shamt;
  logic [31:0] ex_pc,     s_ex_pc;
  logic [15:0] stall_cnt;
  logic [1:0]  s_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_imm;
  logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
  logic [31:0] m_pc;
  int          m_stalls;

  always #5 clk = ~clk;

  id_ex_imm_pipe #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .id_ext_op (id_ext_op),
    .ex_stall  (ex_stall),
    .ex_flush  (ex_flush),
    .id_ready  (id_ready),
    .ex_valid  (ex_valid),
    .ex_imm    (ex_imm),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .ex_rd     (ex_rd),
    .ex_shamt  (ex_shamt),
    .ex_pc     (ex_pc),
    .stall_cnt (stall_cnt)
  );

  id_ex_imm_pipe #(.CNT_W(2)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .id_valid  (id_valid),
    .id_instr  (id_instr),
    .id_pc     (id_pc),
    .id_ext_op (id_ext_op),
    .ex_stall  (ex_stall),
    .ex_flush  (ex_flush),
    .id_ready  (s_id_ready),
    .ex_valid  (s_ex_valid),
    .ex_imm    (s_ex_imm),
    .ex_rs     (s_ex_rs),
    .ex_rt     (s_ex_rt),
    .ex_rd     (s_ex_rd),
    .ex_shamt  (s_ex_shamt),
    .ex_pc     (s_ex_pc),
    .stall_cnt (s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  // Extension rules written as arithmetic on the 16-bit immediate.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] op);
    int s;
    s = $signed(imm);
    case (op)
      2'd0:    return 32'(s);
      2'd1:    return 32'(imm);
      2'd2:    return 32'(imm) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_shamt = '0;
    m_pc = '0; m_stalls = 0;
  endtask

  // What EX should hold after an edge, given the inputs that were present.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (ex_stall) m_stalls++;
      if (ex_flush || (!ex_stall && !id_valid)) begin
        m_valid = 1'b0; m_imm = '0; m_rs = '0; m_rt = '0; m_rd = '0;
        m_shamt = '0; m_pc = '0;
      end else if (!ex_stall) begin
        m_valid = 1'b1;
        m_imm   = ref_ext(id_instr[15:0], id_ext_op);
        m_rs    = 5'((id_instr >> 21) % 32);
        m_rt    = 5'((id_instr >> 16) % 32);
        m_rd    = 5'((id_instr >> 11) % 32);
        m_shamt = 5'((id_instr >> 6) % 32);
        m_pc    = id_pc;
      end
    end
  endtask

  task automatic check_all();
    int cnt16, cnt2;
    cnt16 = (m_stalls > 65535) ? 65535 : m_stalls;
    cnt2  = (m_stalls > 3) ? 3 : m_stalls;
    check("ex_valid",  32'(ex_valid), 32'(m_valid));
    check("ex_imm",    ex_imm, m_imm);
    check("ex_rs",     32'(ex_rs), 32'(m_rs));
    check("ex_rt",     32'(ex_rt), 32'(m_rt));
    check("ex_rd",     32'(ex_rd), 32'(m_rd));
    check("ex_shamt",  32'(ex_shamt), 32'(m_shamt));
    check("ex_pc",     ex_pc, m_pc);
    check("stall_cnt", 32'(stall_cnt), 32'(cnt16));
    check("small_valid", 32'(s_ex_valid), 32'(m_valid));
    check("small_imm",   s_ex_imm, m_imm);
    check("small_pc",    s_ex_pc, m_pc);
    check("small_fields", {12'b0, s_ex_rs, s_ex_rt, s_ex_rd, s_ex_shamt},
                           {12'b0, m_rs, m_rt, m_rd, m_shamt});
    check("small_cnt",   32'(s_stall_cnt), 32'(cnt2));
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [1:0] op, input logic stall, input logic flush);
    id_valid = v; id_instr = instr; id_pc = pc; id_ext_op = op;
    ex_stall = stall; ex_flush = flush;
    #1;
    check("id_ready",       32'(id_ready),   32'(!stall));
    check("small_id_ready", 32'(s_id_ready), 32'(!stall));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    id_valid = 0; id_instr = '0; id_pc = '0; id_ext_op = 2'b00;
    ex_stall = 0; ex_flush = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // LUI $1, 0x1234
    drive(1, 32'h3C011234, 32'h0000_0100, 2'b10, 0, 0);
    tick();
    check("lui_imm",   ex_imm, 32'h1234_0000);
    check("lui_rt",    32'(ex_rt), 32'd1);
    check("lui_valid", 32'(ex_valid), 32'd1);

    // Extension forms
    drive(1, 32'h2001_8000, 32'h0000_0104, 2'b00, 0, 0);
    tick();
    check("sign_8000", ex_imm, 32'hFFFF_8000);
    drive(1, 32'h3401_8000, 32'h0000_0108, 2'b01, 0, 0);
    tick();
    check("zero_8000", ex_imm, 32'h0000_8000);
    drive(1, 32'h1000_FFFF, 32'h0000_010C, 2'b11, 0, 0);
    tick();
    check("branch_ffff", ex_imm, 32'hFFFF_FFFC);

    // Stall for three cycles while ID changes underneath
    drive(1, 32'h8C22_0004, 32'h0000_0040, 2'b00, 0, 0);
    tick();
    check("stall_load_pc", ex_pc, 32'h0000_0040);
    for (int i = 0; i < 3; i++) begin
      drive(1, $urandom, 32'h44 + 32'(4 * i), 2'($urandom_range(0, 3)), 1, 0);
      tick();
      check("stall_hold_pc", ex_pc, 32'h0000_0040);
    end
    check("stall_cnt_3", 32'(stall_cnt), 32'd3);
    drive(1, 32'h0085_1020, 32'h0000_0050, 2'b00, 0, 0);
    tick();
    check("stall_release_pc", ex_pc, 32'h0000_0050);

    // Flush beats a simultaneous stall, stall still counted
    drive(1, 32'h2402_FFFF, 32'h0000_0054, 2'b00, 1, 1);
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_imm",   ex_imm, 32'd0);
    check("flush_pc",    ex_pc, 32'd0);
    check("flush_cnt",   32'(stall_cnt), 32'd4);

    // Idle ID slot becomes a bubble
    drive(1, 32'h2403_0007, 32'h0000_0058, 2'b00, 0, 0);
    tick();
    drive(0, 32'hFFFF_FFFF, 32'h0000_005C, 2'b00, 0, 0);
    tick();
    check("bubble_valid", 32'(ex_valid), 32'd0);
    check("bubble_imm",   ex_imm, 32'd0);
    check("bubble_pc",    ex_pc, 32'd0);

    // Narrow counter saturates
    for (int i = 0; i < 5; i++) begin
      drive(1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1, 0);
      tick();
    end
    check("sat_small_cnt", 32'(s_stall_cnt), 32'd3);
    check("sat_wide_cnt",  32'(stall_cnt), 32'd9);

    // Reset asserted between edges in the middle of a stall
    drive(1, 32'h2404_1111, 32'h0000_0200, 2'b01, 0, 0);
    tick();
    drive(1, 32'h2405_2222, 32'h0000_0204, 2'b01, 1, 0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_valid",     32'(ex_valid), 32'd0);
    check("rst_imm",       ex_imm, 32'd0);
    check("rst_pc",        ex_pc, 32'd0);
    check("rst_cnt",       32'(stall_cnt), 32'd0);
    check("rst_small_cnt", 32'(s_stall_cnt), 32'd0);
    check_all();
    tick();
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), $urandom, $urandom, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_id_ex_imm_pipe
